// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl
//  Purpose  : Machine-mode trap controller. Accepts one synchronous exception,
//             MRET or external interrupt in IDLE. One cycle later it issues a
//             CSR write strobe plus a pipeline flush. One cycle after that it
//             issues a PC redirect, then returns to IDLE.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_i          clock (rising edge), synchronous active-high reset
//    valid_i               instruction trap info valid this cycle
//    pc_i, inst_i          PC and encoding of that instruction
//    badaddr_i             faulting address for misaligned accesses
//    exc_i[5:0]            inst_mis, illegal, ebreak, ecall, load_mis, store_mis
//    mret_i                MRET retiring
//    irq_ext_i             external interrupt level
//    mstatus_i..mtvec_i    current CSR values
//    we_exc_o              CSR exception-write strobe (one cycle)
//    mcause_o, mepc_o,
//    mtval_o, mstatus_o    CSR write data, held between events
//    flush_o               pipeline kill (one cycle, with we_exc_o)
//    redirect_o            PC redirect strobe (one cycle)
//    redirect_pc_o         redirect target, held between events
//    busy_o                controller not IDLE; pipeline stalls
//  Configuration
//    TRAP_VECTORED_EN      when defined, interrupts with mtvec_i[1:0]=2'b01
//                          vector to base + 4*cause
// ============================================================================
module trap_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] badaddr_i,
    input  logic [5:0]  exc_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mcause_i,
    input  logic [31:0] mtval_i,
    input  logic [31:0] mtvec_i,
    output logic        we_exc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtval_o,
    output logic [31:0] mstatus_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    localparam logic [31:0] c_IRQ_CAUSE   = 32'h8000_000B;
    localparam logic [31:0] c_IRQ_VEC_OFS = 32'h0000_002C;  // 4 * 11

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TRAP_WR  = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic        w_any_exc;
    logic        w_exc_take;
    logic        w_mret_take;
    logic        w_irq_take;
    logic        w_accept;
    logic [31:0] w_cause;
    logic [31:0] w_mtval;
    logic [31:0] w_mstatus;
    logic [31:0] w_mtvec_base;
    logic [31:0] w_trap_target;

    logic        r_we;
    logic        r_flush;
    logic        r_redirect;
    logic [31:0] r_mcause;
    logic [31:0] r_mepc;
    logic [31:0] r_mtval;
    logic [31:0] r_mstatus;
    logic [31:0] r_target;
    logic [31:0] r_redirect_pc;

    // ------------------------------------------------------------------
    // Event acceptance
    // ------------------------------------------------------------------
    assign w_any_exc    = |exc_i;
    assign w_exc_take   = valid_i & w_any_exc;
    assign w_mret_take  = valid_i & mret_i & ~w_any_exc;
    // An interrupt does not need valid_i. It yields to any raised exception
    // flag or MRET in the same cycle, whether or not valid_i is set.
    assign w_irq_take   = irq_ext_i & mstatus_i[3] & mie_i[11]
                        & ~w_any_exc & ~mret_i;
    assign w_accept     = (r_state == S_IDLE)
                        & (w_exc_take | w_mret_take | w_irq_take);
    assign w_mtvec_base = {mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign w_trap_target = (w_irq_take && (mtvec_i[1:0] == 2'b01))
                         ? (w_mtvec_base + c_IRQ_VEC_OFS) : w_mtvec_base;
`else
    assign w_trap_target = w_mtvec_base;
`endif

    // Fixed-priority cause / tval selection, bit 0 highest.
    always_comb begin
        w_cause = c_IRQ_CAUSE;
        w_mtval = 32'h0;
        if (w_exc_take) begin
            if (exc_i[0]) begin
                w_cause = 32'd0;
                w_mtval = badaddr_i;
            end else if (exc_i[1]) begin
                w_cause = 32'd2;
                w_mtval = inst_i;
            end else if (exc_i[2]) begin
                w_cause = 32'd3;
            end else if (exc_i[3]) begin
                w_cause = 32'd11;
            end else if (exc_i[4]) begin
                w_cause = 32'd4;
                w_mtval = badaddr_i;
            end else begin
                w_cause = 32'd6;
                w_mtval = badaddr_i;
            end
        end
    end

    // mstatus update: trap entry stacks MIE into MPIE; MRET restores it.
    always_comb begin
        w_mstatus        = mstatus_i;
        w_mstatus[12:11] = 2'b11;
        if (w_mret_take) begin
            w_mstatus[3] = mstatus_i[7];
            w_mstatus[7] = 1'b1;
        end else begin
            w_mstatus[7] = mstatus_i[3];
            w_mstatus[3] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_nxt = S_TRAP_WR;
            S_TRAP_WR:  w_state_nxt = S_REDIRECT;
            S_REDIRECT: w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers. Data registers only change on acceptance (CSR data)
    // or on entry to REDIRECT (target), so they hold between events.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we          <= 1'b0;
            r_flush       <= 1'b0;
            r_redirect    <= 1'b0;
            r_mcause      <= 32'h0;
            r_mepc        <= 32'h0;
            r_mtval       <= 32'h0;
            r_mstatus     <= 32'h0;
            r_target      <= 32'h0;
            r_redirect_pc <= 32'h0;
        end else begin
            r_we       <= w_accept;
            r_flush    <= w_accept;
            r_redirect <= (r_state == S_TRAP_WR);
            if (w_accept) begin
                r_mstatus <= w_mstatus;
                if (w_mret_take) begin
                    r_mcause <= mcause_i;
                    r_mepc   <= mepc_i;
                    r_mtval  <= mtval_i;
                    r_target <= mepc_i;
                end else begin
                    r_mcause <= w_cause;
                    r_mepc   <= {pc_i[31:2], 2'b00};
                    r_mtval  <= w_mtval;
                    r_target <= w_trap_target;
                end
            end
            if (r_state == S_TRAP_WR) begin
                r_redirect_pc <= r_target;
            end
        end
    end

    assign we_exc_o      = r_we;
    assign flush_o       = r_flush;
    assign redirect_o    = r_redirect;
    assign mcause_o      = r_mcause;
    assign mepc_o        = r_mepc;
    assign mtval_o       = r_mtval;
    assign mstatus_o     = r_mstatus;
    assign redirect_pc_o = r_redirect_pc;
    assign busy_o        = (r_state != S_IDLE);

    // Input bits that carry no meaning for this block.
    logic w_unused_bits;
    assign w_unused_bits = ^{pc_i[1:0], mie_i[31:12], mie_i[10:0], mtvec_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trap_ctrl
//  Purpose  : Directed self-checking bench for trap_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i, inst_i, badaddr_i;
    logic [5:0]  exc_i;
    logic        mret_i, irq_ext_i;
    logic [31:0] mstatus_i, mie_i, mepc_i, mcause_i, mtval_i, mtvec_i;
    logic        we_exc_o, flush_o, redirect_o, busy_o;
    logic [31:0] mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    trap_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .pc_i          (pc_i),
        .inst_i        (inst_i),
        .badaddr_i     (badaddr_i),
        .exc_i         (exc_i),
        .mret_i        (mret_i),
        .irq_ext_i     (irq_ext_i),
        .mstatus_i     (mstatus_i),
        .mie_i         (mie_i),
        .mepc_i        (mepc_i),
        .mcause_i      (mcause_i),
        .mtval_i       (mtval_i),
        .mtvec_i       (mtvec_i),
        .we_exc_o      (we_exc_o),
        .mcause_o      (mcause_o),
        .mepc_o        (mepc_o),
        .mtval_o       (mtval_o),
        .mstatus_o     (mstatus_o),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .busy_o        (busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Strobes and busy in one call: {we, flush, redirect, busy}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'h0, we_exc_o, flush_o, redirect_o, busy_o}, {28'h0, exp});
    endtask

    task automatic quiet();
        valid_i   = 1'b0;
        exc_i     = 6'b0;
        mret_i    = 1'b0;
        irq_ext_i = 1'b0;
    endtask

    logic [31:0] exp_vec;

    initial begin
`ifdef TRAP_VECTORED_EN
        exp_vec = 32'h0000_102C;
`else
        exp_vec = 32'h0000_1000;
`endif
        rst_i = 1'b1;
        quiet();
        pc_i = 32'h0; inst_i = 32'h0; badaddr_i = 32'h0;
        mstatus_i = 32'h0; mie_i = 32'h0; mepc_i = 32'h0;
        mcause_i = 32'h0; mtval_i = 32'h0; mtvec_i = 32'h0000_2000;

        // Reset state
        tick(); tick();
        chk_ctl("rst_ctl", 4'b0000);
        chk("rst_mcause", mcause_o, 32'h0);
        chk("rst_mstatus", mstatus_o, 32'h0);
        chk("rst_rpc", redirect_pc_o, 32'h0);
        rst_i = 1'b0;
        tick();

        // Illegal instruction
        valid_i = 1'b1; pc_i = 32'h100; exc_i = 6'b000010;
        inst_i = 32'hFFFF_FFFF; mstatus_i = 32'h8;
        tick();
        quiet();
        chk_ctl("ill_n1_ctl", 4'b1101);
        chk("ill_mcause", mcause_o, 32'd2);
        chk("ill_mepc", mepc_o, 32'h100);
        chk("ill_mtval", mtval_o, 32'hFFFF_FFFF);
        chk("ill_mstatus", mstatus_o, 32'h1880);
        tick();
        chk_ctl("ill_n2_ctl", 4'b0011);
        chk("ill_rpc", redirect_pc_o, 32'h2000);
        chk("ill_hold_mcause", mcause_o, 32'd2);
        tick();
        chk_ctl("ill_n3_ctl", 4'b0000);

        // Bit 0 beats bit 4; mepc alignment
        valid_i = 1'b1; pc_i = 32'h206; exc_i = 6'b010001; badaddr_i = 32'h203;
        tick();
        quiet();
        chk_ctl("pri_ctl", 4'b1101);
        chk("pri_mcause", mcause_o, 32'd0);
        chk("pri_mtval", mtval_o, 32'h203);
        chk("pri_mepc", mepc_o, 32'h204);
        tick(); tick();

        // MRET
        valid_i = 1'b1; mret_i = 1'b1; mepc_i = 32'h400; mstatus_i = 32'h1880;
        mcause_i = 32'h55; mtval_i = 32'h66;
        tick();
        quiet();
        chk_ctl("mret_ctl", 4'b1101);
        chk("mret_mstatus", mstatus_o, 32'h1888);
        chk("mret_mcause", mcause_o, 32'h55);
        chk("mret_mtval", mtval_o, 32'h66);
        chk("mret_mepc", mepc_o, 32'h400);
        tick();
        chk_ctl("mret_n2_ctl", 4'b0011);
        chk("mret_rpc", redirect_pc_o, 32'h400);
        tick();

        // External interrupt, no valid_i
        irq_ext_i = 1'b1; mie_i = 32'h800; mstatus_i = 32'h8;
        mtvec_i = 32'h1001; pc_i = 32'h300;
        tick();
        quiet();
        chk_ctl("irq_ctl", 4'b1101);
        chk("irq_mcause", mcause_o, 32'h8000_000B);
        chk("irq_mtval", mtval_o, 32'h0);
        chk("irq_mstatus", mstatus_o, 32'h1880);
        tick();
        chk_ctl("irq_n2_ctl", 4'b0011);
        chk("irq_rpc", redirect_pc_o, exp_vec);
        tick();

        // Sync exception with vectored mtvec always uses base
        valid_i = 1'b1; exc_i = 6'b001000;
        tick();
        quiet();
        chk("ecall_mcause", mcause_o, 32'd11);
        chk("ecall_mtval", mtval_o, 32'h0);
        tick();
        chk("ecall_rpc", redirect_pc_o, 32'h1000);
        tick();

        // Interrupt masked by MIE=0 -> nothing
        irq_ext_i = 1'b1; mstatus_i = 32'h0;
        tick();
        chk_ctl("irq_mask_ctl", 4'b0000);
        tick();
        quiet();
        chk_ctl("irq_mask_ctl2", 4'b0000);

        // valid_i with no flags -> nothing
        valid_i = 1'b1; mstatus_i = 32'h8;
        tick();
        quiet();
        chk_ctl("noflag_ctl", 4'b0000);

        // Exception beats simultaneous interrupt
        valid_i = 1'b1; exc_i = 6'b000100; irq_ext_i = 1'b1;
        tick();
        quiet();
        chk("exc_vs_irq_mcause", mcause_o, 32'd3);
        tick(); tick();

        // Reset in TRAP_WR drops the sequence
        valid_i = 1'b1; exc_i = 6'b000010;
        tick();
        quiet();
        chk_ctl("rstmid_pre_ctl", 4'b1101);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk_ctl("rstmid_ctl", 4'b0000);
        chk("rstmid_mcause", mcause_o, 32'h0);
        chk("rstmid_mtval", mtval_o, 32'h0);
        tick();
        chk_ctl("rstmid_noredir", 4'b0000);
        chk("rstmid_rpc", redirect_pc_o, 32'h0);

        // Reset wins over a same-cycle event
        rst_i = 1'b1; valid_i = 1'b1; exc_i = 6'b000010;
        tick();
        rst_i = 1'b0;
        quiet();
        chk_ctl("rstpri_ctl", 4'b0000);
        tick();
        chk_ctl("rstpri_ctl2", 4'b0000);

        // Inputs ignored while busy: one pulse only
        valid_i = 1'b1; exc_i = 6'b001000;
        tick();
        exc_i = 6'b000010;  // held through TRAP_WR
        chk_ctl("busy_n1_ctl", 4'b1101);
        chk("busy_mcause", mcause_o, 32'd11);
        tick();
        quiet();
        chk_ctl("busy_n2_ctl", 4'b0011);
        chk("busy_hold_mcause", mcause_o, 32'd11);
        tick();
        chk_ctl("busy_n3_ctl", 4'b0000);
        tick();
        chk_ctl("busy_n4_ctl", 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
